// File: rtl/ptmch_pkg.sv
// Shared constants and state types for the multi-channel trigger generator.
package ptmch_pkg;

  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_PERIOD     = 8'h01;
  localparam logic [7:0] ADDR_POL        = 8'h02;
  localparam logic [7:0] ADDR_DELAY_BASE = 8'h10;
  localparam logic [7:0] ADDR_WIDTH_BASE = 8'h20;

  localparam int CTRL_RUN_BIT     = 0;
  localparam int CTRL_ONESHOT_BIT = 1;
  localparam int CTRL_ERR_CLR_BIT = 2;

  localparam int FRAME_BITS = 24;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_SHIFT,
    SPI_COMMIT
  } spi_state_t;

  typedef enum logic {
    SEQ_STOP,
    SEQ_RUN
  } seq_state_t;

endpackage

// File: rtl/ptmch_spi_rx.sv
// SPI mode-0 receiver oversampled by the system clock; emits one addr/data
// strobe per complete 24-bit frame.
//   state      | meaning
//   SPI_IDLE   | waiting for a CS fall
//   SPI_SHIFT  | CS low, shifting MOSI on each SPI_CLK rise
//   SPI_COMMIT | 24 bits captured, present addr/data for one cycle
module ptmch_spi_rx
  import ptmch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic [7:0]  addr,
  output logic [15:0] data,
  output logic        valid
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_prev;
  logic                   sclk_prev;

  // Synchroniser is left out of reset so a CS held low through reset
  // is not mistaken for a fresh CS fall afterwards.
  always_ff @(posedge clk) begin
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    cs_prev   <= cs_sync[SYNC_STAGES-1];
    sclk_prev <= sclk_sync[SYNC_STAGES-1];
  end

  logic cs_s, mosi_s, sclk_rise, cs_fall;
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign cs_fall   = cs_prev & ~cs_s;

  spi_state_t  state;
  logic [4:0]  bit_cnt;
  logic [23:0] shift_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SPI_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      addr      <= '0;
      data      <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        SPI_IDLE: begin
          bit_cnt <= '0;
          if (cs_fall) state <= SPI_SHIFT;
        end
        SPI_SHIFT: begin
          if (cs_s) begin
            state <= SPI_IDLE;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[22:0], mosi_s};
            bit_cnt   <= bit_cnt + 5'd1;
            if (bit_cnt == 5'(FRAME_BITS - 1)) state <= SPI_COMMIT;
          end
        end
        SPI_COMMIT: begin
          // Trailing bits are dropped: IDLE only re-arms on the next CS fall.
          addr  <= shift_reg[23:16];
          data  <= shift_reg[15:0];
          valid <= 1'b1;
          state <= SPI_IDLE;
        end
        default: state <= SPI_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ptmch_multi_trg.sv
// Multi-channel period/delay/width trigger generator configured over SPI.
//   state    | meaning
//   SEQ_STOP | counter held at 0, shadows copied to active every cycle
//   SEQ_RUN  | counter runs 0..PERIOD, shadows copied on the wrap cycle
module ptmch_multi_trg
  import ptmch_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK160M,
  input  logic              RESET,
  input  logic              SPI_CS,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  output logic [NUM_CH-1:0] TRG_PLS,
  output logic              BUSY,
  output logic              CFG_ERR
);

  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_valid;

  ptmch_spi_rx #(.SYNC_STAGES(SYNC_STAGES)) u_spi_rx (
    .clk      (CLK160M),
    .reset    (RESET),
    .spi_cs   (SPI_CS),
    .spi_clk  (SPI_CLK),
    .spi_mosi (SPI_MOSI),
    .addr     (wr_addr),
    .data     (wr_data),
    .valid    (wr_valid)
  );

  logic [CNT_W-1:0]  wr_val;
  logic              hit_ctrl, hit_period, hit_pol, bad_addr;
  logic [NUM_CH-1:0] hit_delay, hit_width;

  assign wr_val = wr_data[CNT_W-1:0];

  always_comb begin
    hit_ctrl   = wr_valid && (wr_addr == ADDR_CTRL);
    hit_period = wr_valid && (wr_addr == ADDR_PERIOD);
    hit_pol    = wr_valid && (wr_addr == ADDR_POL);
    for (int i = 0; i < NUM_CH; i++) begin
      hit_delay[i] = wr_valid && (wr_addr == ADDR_DELAY_BASE + 8'(i));
      hit_width[i] = wr_valid && (wr_addr == ADDR_WIDTH_BASE + 8'(i));
    end
    bad_addr = wr_valid && !(hit_ctrl || hit_period || hit_pol ||
                             (|hit_delay) || (|hit_width));
  end

  logic [CNT_W-1:0]  period_sh, period_nxt, period_act;
  logic [NUM_CH-1:0] pol_sh, pol_nxt, pol_act;
  logic [CNT_W-1:0]  delay_sh [NUM_CH];
  logic [CNT_W-1:0]  delay_nxt[NUM_CH];
  logic [CNT_W-1:0]  delay_act[NUM_CH];
  logic [CNT_W-1:0]  width_sh [NUM_CH];
  logic [CNT_W-1:0]  width_nxt[NUM_CH];
  logic [CNT_W-1:0]  width_act[NUM_CH];

  // The active copy loads from the post-write shadow value, so a commit
  // landing on the wrap cycle takes effect in the very next period.
  always_comb begin
    period_nxt = hit_period ? wr_val : period_sh;
    pol_nxt    = hit_pol ? wr_data[NUM_CH-1:0] : pol_sh;
    for (int i = 0; i < NUM_CH; i++) begin
      delay_nxt[i] = hit_delay[i] ? wr_val : delay_sh[i];
      width_nxt[i] = hit_width[i] ? wr_val : width_sh[i];
    end
  end

  seq_state_t        seq_state;
  logic [CNT_W-1:0]  cnt;
  logic              oneshot;
  logic              wrap, load_active;
  logic [NUM_CH-1:0] raw;

  assign wrap        = (seq_state == SEQ_RUN) && (cnt == period_act);
  assign load_active = (seq_state == SEQ_STOP) || wrap;

  // End of window is compared one bit wider so DELAY+WIDTH cannot wrap.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = (seq_state == SEQ_RUN) && (cnt >= delay_act[i]) &&
               ({1'b0, cnt} < ({1'b0, delay_act[i]} + {1'b0, width_act[i]}));
    end
  end

  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      seq_state  <= SEQ_STOP;
      cnt        <= '0;
      oneshot    <= 1'b0;
      CFG_ERR    <= 1'b0;
      TRG_PLS    <= '0;
      period_sh  <= '0;
      period_act <= '0;
      pol_sh     <= '0;
      pol_act    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        delay_sh[i]  <= '0;
        delay_act[i] <= '0;
        width_sh[i]  <= '0;
        width_act[i] <= '0;
      end
    end else begin
      period_sh <= period_nxt;
      pol_sh    <= pol_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        delay_sh[i] <= delay_nxt[i];
        width_sh[i] <= width_nxt[i];
      end
      if (load_active) begin
        period_act <= period_nxt;
        pol_act    <= pol_nxt;
        for (int i = 0; i < NUM_CH; i++) begin
          delay_act[i] <= delay_nxt[i];
          width_act[i] <= width_nxt[i];
        end
      end

      if (bad_addr) CFG_ERR <= 1'b1;
      else if (hit_ctrl && wr_data[CTRL_ERR_CLR_BIT]) CFG_ERR <= 1'b0;

      if (hit_ctrl) oneshot <= wr_data[CTRL_ONESHOT_BIT];

      case (seq_state)
        SEQ_STOP: begin
          cnt <= '0;
          if (hit_ctrl && wr_data[CTRL_RUN_BIT] && (period_act != '0))
            seq_state <= SEQ_RUN;
        end
        SEQ_RUN: begin
          if (hit_ctrl && !wr_data[CTRL_RUN_BIT]) begin
            seq_state <= SEQ_STOP;
            cnt       <= '0;
          end else if (wrap) begin
            cnt <= '0;
            if (oneshot) seq_state <= SEQ_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: seq_state <= SEQ_STOP;
      endcase

      TRG_PLS <= raw ^ pol_act;
    end
  end

  assign BUSY = (seq_state == SEQ_RUN);

endmodule

// File: tb/tb_ptmch_multi_trg.sv
// Randomised and directed checks of the trigger generator against a
// period/window arithmetic model.
module tb_ptmch_multi_trg;
  import ptmch_pkg::*;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;

  logic              CLK160M  = 1'b0;
  logic              RESET    = 1'b1;
  logic              SPI_CS   = 1'b1;
  logic              SPI_CLK  = 1'b0;
  logic              SPI_MOSI = 1'b0;
  logic [NUM_CH-1:0] TRG_PLS;
  logic              BUSY;
  logic              CFG_ERR;

  int checks = 0;
  int errors = 0;

  ptmch_multi_trg #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .CLK160M  (CLK160M),
    .RESET    (RESET),
    .SPI_CS   (SPI_CS),
    .SPI_CLK  (SPI_CLK),
    .SPI_MOSI (SPI_MOSI),
    .TRG_PLS  (TRG_PLS),
    .BUSY     (BUSY),
    .CFG_ERR  (CFG_ERR)
  );

  always #3 CLK160M = ~CLK160M;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model registers: m_* before the mid-run switch, n_* from period m_switch on.
  int                m_period;
  logic [NUM_CH-1:0] m_pol;
  int                m_delay[NUM_CH], m_width[NUM_CH];
  int                n_delay[NUM_CH], n_width[NUM_CH];
  int                m_switch;
  int                k_now;

  function automatic logic [NUM_CH-1:0] exp_trg(input int k, input bit oneshot);
    logic [NUM_CH-1:0] r;
    int p1, c, per, d, w;
    r  = m_pol;
    p1 = m_period + 1;
    if (k >= 1 && (!oneshot || k <= p1)) begin
      c   = (k - 1) % p1;
      per = (k - 1) / p1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        d = (per >= m_switch) ? n_delay[ch] : m_delay[ch];
        w = (per >= m_switch) ? n_width[ch] : m_width[ch];
        if (c >= d && c < d + w) r[ch] = ~r[ch];
      end
    end
    return r;
  endfunction

  task automatic spi_bit(input logic v);
    SPI_MOSI = v;
    repeat (4) @(negedge CLK160M);
    SPI_CLK = 1'b1;
    repeat (4) @(negedge CLK160M);
    SPI_CLK = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] a, input logic [15:0] d, input int nbits);
    logic [31:0] f;
    f = {a, d, 8'h00};
    SPI_CS = 1'b0;
    repeat (8) @(negedge CLK160M);
    for (int b = 0; b < nbits; b++) spi_bit(f[31-b]);
    repeat (8) @(negedge CLK160M);
    SPI_CS = 1'b1;
    repeat (8) @(negedge CLK160M);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    spi_frame(a, d, 24);
  endtask

  task automatic configure();
    wr(ADDR_PERIOD, 16'(m_period));
    wr(ADDR_POL, 16'(m_pol));
    for (int ch = 0; ch < NUM_CH; ch++) begin
      wr(ADDR_DELAY_BASE + 8'(ch), 16'(m_delay[ch]));
      wr(ADDR_WIDTH_BASE + 8'(ch), 16'(m_width[ch]));
      n_delay[ch] = m_delay[ch];
      n_width[ch] = m_width[ch];
    end
    m_switch = 1 << 30;
  endtask

  // k = 0 is the first cycle BUSY is seen high (counter at 0); the output
  // at sample k reflects the counter value of sample k-1.
  task automatic run_and_check(input string tag, input int ncyc, input bit oneshot, input int mid_k);
    k_now = -1;
    fork
      begin : writer
        int g;
        wr(ADDR_CTRL, oneshot ? 16'h0003 : 16'h0001);
        if (mid_k >= 0) begin
          g = 0;
          while (k_now < mid_k && g < 20000) begin
            @(negedge CLK160M);
            g++;
          end
          wr(ADDR_DELAY_BASE, 16'(n_delay[0]));
        end
      end
      begin : watcher
        int g;
        bit started;
        g = 0;
        started = 0;
        while (!started && g < 1000) begin
          @(negedge CLK160M);
          if (BUSY) started = 1;
          g++;
        end
        if (!started) begin
          check($sformatf("%s busy_start", tag), 32'(BUSY), 32'd1);
          k_now = 1 << 30;
        end else begin
          for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge CLK160M);
            k_now = k;
            check($sformatf("%s trg k=%0d", tag, k), 32'(TRG_PLS), 32'(exp_trg(k, oneshot)));
            check($sformatf("%s busy k=%0d", tag, k), 32'(BUSY),
                  32'((!oneshot || k <= m_period) ? 1 : 0));
          end
        end
      end
    join
  endtask

  task automatic stop_and_check(input string tag);
    wr(ADDR_CTRL, 16'h0000);
    check($sformatf("%s stop busy", tag), 32'(BUSY), 32'd0);
    check($sformatf("%s stop trg", tag), 32'(TRG_PLS), 32'(m_pol));
  endtask

  task automatic set_model(input int p, input logic [NUM_CH-1:0] pol,
                           input int d0, input int w0, input int d1, input int w1);
    m_period = p;
    m_pol    = pol;
    m_delay[0] = d0; m_width[0] = w0;
    m_delay[1] = d1; m_width[1] = w1;
  endtask

  initial begin
    repeat (5) @(negedge CLK160M);
    RESET = 1'b0;
    @(negedge CLK160M);
    check("reset trg", 32'(TRG_PLS), 32'd0);
    check("reset busy", 32'(BUSY), 32'd0);
    check("reset cfg_err", 32'(CFG_ERR), 32'd0);

    wr(ADDR_CTRL, 16'h0001);
    repeat (10) @(negedge CLK160M);
    check("run with period 0", 32'(BUSY), 32'd0);

    // Partial, unmapped and over-long frames.
    set_model(99, 2'b00, 10, 5, 0, 0);
    configure();
    spi_frame(8'h7F, 16'h0000, 16);
    check("partial bad addr", 32'(CFG_ERR), 32'd0);
    spi_frame(ADDR_CTRL, 16'h0001, 16);
    check("partial ctrl run", 32'(BUSY), 32'd0);
    wr(8'h7F, 16'h1234);
    check("bad addr 7f", 32'(CFG_ERR), 32'd1);
    wr(ADDR_CTRL, 16'h0004);
    check("err clear", 32'(CFG_ERR), 32'd0);
    wr(8'h12, 16'h0003);
    check("bad addr past num_ch", 32'(CFG_ERR), 32'd1);
    spi_frame(ADDR_CTRL, 16'h0004, 28);
    check("long frame err clear", 32'(CFG_ERR), 32'd0);
    check("long frame no run", 32'(BUSY), 32'd0);

    run_and_check("basic", 260, 1'b0, -1);
    stop_and_check("basic");

    set_model(49, 2'b00, 0, 0, 0, 3);
    configure();
    run_and_check("oneshot", 160, 1'b1, -1);

    set_model(99, 2'b00, 10, 5, 0, 0);
    configure();
    n_delay[0] = 50;
    m_switch   = 4;
    run_and_check("shadow", 620, 1'b0, 107);
    stop_and_check("shadow");

    set_model(19, 2'b01, 18, 10, 3, 2);
    configure();
    run_and_check("polwrap", 90, 1'b0, -1);
    stop_and_check("polwrap");

    for (int t = 0; t < 4; t++) begin
      int p;
      bit os;
      p = int'($urandom_range(40, 3));
      set_model(p, 2'($urandom), int'($urandom_range(p + 3, 0)), int'($urandom_range(p + 3, 0)),
                int'($urandom_range(p + 3, 0)), int'($urandom_range(p + 3, 0)));
      os = 1'($urandom);
      configure();
      run_and_check($sformatf("rand%0d", t), 3 * (p + 1) + 6, os, -1);
      stop_and_check($sformatf("rand%0d", t));
    end

    // Reset in the middle of a pulse and of a frame.
    set_model(99, 2'b00, 10, 60, 5, 20);
    configure();
    wr(ADDR_CTRL, 16'h0001);
    begin : wait_pulse
      int g;
      g = 0;
      while (!TRG_PLS[0] && g < 500) begin
        @(negedge CLK160M);
        g++;
      end
      check("pulse before reset", 32'(TRG_PLS[0]), 32'd1);
    end
    SPI_CS = 1'b0;
    repeat (8) @(negedge CLK160M);
    for (int b = 0; b < 5; b++) spi_bit(1'b0);
    RESET = 1'b1;
    @(negedge CLK160M);
    RESET = 1'b0;
    @(negedge CLK160M);
    check("mid reset trg", 32'(TRG_PLS), 32'd0);
    check("mid reset busy", 32'(BUSY), 32'd0);
    check("mid reset cfg_err", 32'(CFG_ERR), 32'd0);
    begin : stale_frame
      logic [23:0] f;
      f = {ADDR_PERIOD, 16'd9};
      for (int b = 0; b < 24; b++) spi_bit(f[23-b]);
    end
    repeat (8) @(negedge CLK160M);
    SPI_CS = 1'b1;
    repeat (8) @(negedge CLK160M);
    wr(ADDR_CTRL, 16'h0001);
    repeat (10) @(negedge CLK160M);
    check("frame without cs fall ignored", 32'(BUSY), 32'd0);

    set_model(29, 2'b10, 4, 6, 25, 10);
    configure();
    run_and_check("after reset", 100, 1'b0, -1);
    stop_and_check("after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptmch_multi_trg.md
PTMCH_MULTI_TRG -- requirements
Module: ptmch_multi_trg

Interface
REQ-001 Parameter NUM_CH, default 2, number of trigger channels (legal 1..8).
REQ-002 Parameter CNT_W, default 16, width of period/delay/width counters (legal 8..16).
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth for SPI inputs (legal 2..3).
REQ-004 CLK160M  input  1  sole clock, 160 MHz; all logic on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 SPI_CS  input  1  SPI chip select, asynchronous, active-low.
REQ-007 SPI_CLK  input  1  SPI clock, asynchronous, mode 0; data sampled on SPI_CLK rising edge.
REQ-008 SPI_MOSI  input  1  SPI serial data, MSB first.
REQ-009 TRG_PLS  output  NUM_CH  registered trigger pulses, one bit per channel.
REQ-010 BUSY  output  1  high while the period sequencer is in RUN.
REQ-011 CFG_ERR  output  1  sticky flag: write to an unmapped address; cleared by CTRL write with bit2=1.

Function
REQ-012 SPI_CS, SPI_CLK and SPI_MOSI SHALL pass through SYNC_STAGES flip-flops; SPI_CLK rise SHALL be detected by edge compare in CLK160M domain (max SPI_CLK 20 MHz).
REQ-013 SPI FSM states: IDLE (CS high), SHIFT (CS low, shift MOSI on each detected SPI_CLK rise), COMMIT (one cycle, write register); CS fall moves IDLE->SHIFT.
REQ-014 Frame = 24 bits: addr[23:16], data[15:0]; 24th bit moves SHIFT->COMMIT; bits after the 24th until CS rise SHALL be ignored.
REQ-015 CS rise with fewer than 24 bits received SHALL discard the frame, no register change, return to IDLE.
REQ-016 Register map: 0x00 CTRL (bit0 RUN, bit1 ONESHOT, bit2 ERR_CLR); 0x01 PERIOD; 0x02 POL (bit i inverts channel i); 0x10+i DELAY[i]; 0x20+i WIDTH[i], i < NUM_CH; data truncated to CNT_W bits.
REQ-017 Any other address SHALL set CFG_ERR and change nothing.
REQ-018 PERIOD, DELAY, WIDTH, POL writes SHALL land in shadow registers; shadows copy to active registers when sequencer is in STOP or on the wrap cycle (cnt == PERIOD).
REQ-019 Sequencer states STOP and RUN; STOP->RUN on CTRL write with RUN=1 and active PERIOD != 0; RUN->STOP on CTRL write with RUN=0 (immediate) or, if ONESHOT=1, on first wrap.
REQ-020 In RUN, counter cnt SHALL count 0..PERIOD and wrap to 0; in STOP cnt SHALL be held at 0.
REQ-021 CTRL RUN=1 with PERIOD=0 SHALL leave sequencer in STOP.
REQ-022 Channel i raw pulse SHALL be high when in RUN and DELAY[i] <= cnt < DELAY[i]+WIDTH[i], sum computed at CNT_W+1 bits (no wrap).
REQ-023 WIDTH[i]=0 or DELAY[i] > PERIOD SHALL give no pulse; DELAY+WIDTH > PERIOD+1 SHALL truncate at wrap.
REQ-024 TRG_PLS[i] = raw pulse XOR POL[i], registered: one CLK160M cycle after the cnt value that satisfies REQ-022.
REQ-025 RUN->STOP SHALL force raw pulses low on the next cycle (TRG_PLS returns to POL level).
REQ-026 A COMMIT coinciding with a wrap cycle SHALL have its shadow write included in that wrap's copy.

Reset
REQ-027 RESET SHALL set: SPI FSM IDLE, bit count 0, sequencer STOP, cnt 0, all shadow/active registers 0, CFG_ERR 0, BUSY 0, TRG_PLS all 0.
REQ-028 RESET asserted mid-frame or mid-period SHALL abort the frame/period; after release, SPI FSM SHALL wait for next CS fall.

Structure
REQ-029 Package ptmch_pkg SHALL hold register address constants, CTRL bit positions, and SPI/sequencer state enums.
REQ-030 SPI receiver SHALL be a sub-module ptmch_spi_rx (synchroniser, FSM, 24-bit shift, outputs addr/data/valid pulse).

Verification
REQ-031 PERIOD=99, DELAY[0]=10, WIDTH[0]=5, RUN=1 -> TRG_PLS[0] high for 5 cycles, first at cnt=11 equivalent, repeating every 100 cycles; BUSY=1.
REQ-032 ONESHOT=1, PERIOD=49, DELAY[1]=0, WIDTH[1]=3 -> one 3-cycle pulse on TRG_PLS[1], BUSY drops after wrap, no further pulses.
REQ-033 While running PERIOD=99, write DELAY[0]=50 at cnt=20 -> current period still pulses at 10, next period pulses at 50.
REQ-034 Frame of 16 bits then CS rise -> no register change; next full frame to 0x7F -> CFG_ERR=1; CTRL write 0x0004 -> CFG_ERR=0.
REQ-035 PERIOD=19, DELAY[0]=18, WIDTH[0]=10, POL=0x1 -> TRG_PLS[0] low for cnt 18..19 only, high otherwise.
REQ-036 RESET pulsed for 1 cycle mid-frame and mid-pulse -> TRG_PLS=0, BUSY=0, registers 0; subsequent complete frame accepted normally.
